// File: rtl/bcd2e_rdbuf.sv
// Read-buffer path: sequences print-buffer reads, converts BCD to EBCDIC, queues in a 2-entry FIFO.
// Optional odd-parity checking of returned buffer words is enabled by defining BCD_PARITY_EN.
module bcd2e_rdbuf #(
    parameter int unsigned AW      = 8,
    parameter int unsigned BUF_LEN = 132
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic [AW-1:0] i_first,
    input  logic [AW-1:0] i_count,
    input  logic          i_abort,
    output logic          o_rd,
    output logic [AW-1:0] o_addr,
    input  logic [7:0]    i_rdata,
    output logic          o_valid,
    output logic [7:0]    o_data,
    input  logic          i_ready,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_invalid,
    output logic          o_perr
);

    localparam int unsigned OCC_W = 3;
    localparam logic [AW-1:0] LAST_ADDR = AW'(BUF_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] rem_q, rem_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          rd_q, rd_d;
    logic          pend_q, pend_d;
    logic [7:0]    head_q, head_d;
    logic          head_v_q, head_v_d;
    logic [7:0]    tail_q, tail_d;
    logic          tail_v_q, tail_v_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          inv_q, inv_d;
    logic          perr_q, perr_d;

    logic [7:0]       conv_byte_c;
    logic             conv_inv_c;
    logic [3:0]       zone_c;
    logic             par_err_c;
    logic             pop_c;
    logic [OCC_W-1:0] occ_c;
    logic             issue_c;

`ifdef BCD_PARITY_EN
    assign par_err_c = ~(^i_rdata);
`else
    logic rdata_p_unused;
    assign rdata_p_unused = i_rdata[7];
    assign par_err_c      = 1'b0;
`endif

    // BCD {s,b,a,8421} to EBCDIC; blank wins over everything, unmapped digits flag invalid
    always_comb begin
        conv_byte_c = 8'h40;
        conv_inv_c  = 1'b0;
        zone_c      = 4'hF;
        if (!i_rdata[6]) begin
            if ((i_rdata[3:0] >= 4'd1) && (i_rdata[3:0] <= 4'd9)) begin
                case (i_rdata[5:4])
                    2'b00:   zone_c = 4'hF;
                    2'b01:   zone_c = 4'hE;
                    2'b10:   zone_c = 4'hD;
                    default: zone_c = 4'hC;
                endcase
                conv_byte_c = {zone_c, i_rdata[3:0]};
                if (i_rdata[5:0] == 6'b01_0001) begin
                    conv_byte_c = 8'h61;
                end
            end else begin
                case (i_rdata[5:0])
                    6'b00_1010: conv_byte_c = 8'hF0;
                    6'b00_1011: conv_byte_c = 8'h7B;
                    6'b00_1100: conv_byte_c = 8'h7C;
                    6'b01_1010: conv_byte_c = 8'h50;
                    6'b01_1011: conv_byte_c = 8'h6B;
                    6'b01_1100: conv_byte_c = 8'h6C;
                    6'b10_1010: conv_byte_c = 8'h60;
                    6'b10_1011: conv_byte_c = 8'h5B;
                    6'b10_1100: conv_byte_c = 8'h5C;
                    6'b11_1010: conv_byte_c = 8'h4E;
                    6'b11_1011: conv_byte_c = 8'h4B;
                    6'b11_1100: conv_byte_c = 8'h4C;
                    default:    conv_inv_c  = 1'b1;
                endcase
            end
        end
    end

    assign pop_c   = head_v_q & i_ready;
    // Entries held or owed to the FIFO after this cycle's pop; a new read needs a free slot
    assign occ_c   = OCC_W'(head_v_q) + OCC_W'(tail_v_q) + OCC_W'(rd_q) + OCC_W'(pend_q)
                   - OCC_W'(pop_c);
    assign issue_c = (rem_q != '0) && (occ_c < OCC_W'(2));

    // Next-state, FIFO and flag logic
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        rem_d    = rem_q;
        addr_d   = addr_q;
        rd_d     = 1'b0;
        pend_d   = rd_q;
        head_d   = head_q;
        head_v_d = head_v_q;
        tail_d   = tail_q;
        tail_v_d = tail_v_q;
        done_d   = 1'b0;
        inv_d    = inv_q;
        perr_d   = perr_q;

        if (pop_c) begin
            if (tail_v_q) begin
                head_d = tail_q;
            end
            head_v_d = tail_v_q;
            tail_v_d = 1'b0;
        end
        if (pend_q) begin
            if (!head_v_d) begin
                head_d   = conv_byte_c;
                head_v_d = 1'b1;
            end else begin
                tail_d   = conv_byte_c;
                tail_v_d = 1'b1;
            end
            inv_d  = inv_q | conv_inv_c;
            perr_d = perr_q | par_err_c;
        end

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    inv_d  = 1'b0;
                    perr_d = 1'b0;
                    if (i_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        ptr_d   = i_first;
                        rem_d   = i_count;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (issue_c) begin
                    rd_d   = 1'b1;
                    addr_d = ptr_q;
                    ptr_d  = (ptr_q == LAST_ADDR) ? '0 : ptr_q + AW'(1);
                    rem_d  = rem_q - AW'(1);
                    if (rem_q == AW'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop_c && !tail_v_q && !pend_q && !rd_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort beats everything, including a same-cycle start; flags are kept
        if (i_abort) begin
            state_d  = IDLE;
            rem_d    = '0;
            rd_d     = 1'b0;
            pend_d   = 1'b0;
            head_v_d = 1'b0;
            tail_v_d = 1'b0;
            done_d   = 1'b0;
            inv_d    = inv_q;
            perr_d   = perr_q;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            rem_q    <= '0;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            pend_q   <= 1'b0;
            head_q   <= '0;
            head_v_q <= 1'b0;
            tail_q   <= '0;
            tail_v_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            inv_q    <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            rem_q    <= rem_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            pend_q   <= pend_d;
            head_q   <= head_d;
            head_v_q <= head_v_d;
            tail_q   <= tail_d;
            tail_v_q <= tail_v_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            inv_q    <= inv_d;
            perr_q   <= perr_d;
        end
    end

    assign o_rd      = rd_q;
    assign o_addr    = addr_q;
    assign o_valid   = head_v_q;
    assign o_data    = head_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_invalid = inv_q;
    assign o_perr    = perr_q;

endmodule

// File: doc/bcd2e_rdbuf.md
Name: bcd2e_rdbuf

Overview:
- Read-buffer path for the 2821 printer adapter. The print-line buffer holds chain-order BCD codes; this block returns that buffer to the channel as EBCDIC on a Read Buffer / diagnostic sense command.
- Sequences buffer addresses, issues synchronous reads and converts each BCD code to EBCDIC.
- Queues the converted bytes in a 2-entry FIFO and presents them on a valid/ready channel interface.

Parameters:
AW, 8, buffer address width
BUF_LEN, 132, print positions; last legal address is BUF_LEN-1

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset. Asynchronous and active-low.
- i_start  in  1  one-cycle pulse; starts a transfer. Ignored unless the block is in IDLE.
- i_first  in  AW  first buffer address, sampled on i_start.
- i_count  in  AW  number of bytes to transfer, sampled on i_start. 0 means none.
- i_abort  in  1  terminate the transfer. Any state returns to IDLE.
- o_rd  out  1  buffer read strobe.
- o_addr  out  AW  buffer read address.
- i_rdata  in  8  {p, s, b, a, 8, 4, 2, 1}. Valid exactly 1 cycle after o_rd. s = blank position; p = odd parity over bits 6:0.
- o_valid  out  1  o_data holds a byte.
- o_data  out  8  EBCDIC byte.
- i_ready  in  1  channel accepts o_data.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse when the last byte is accepted.
- o_invalid  out  1  sticky: at least one BCD code had no graphic. Cleared on i_start.
- o_perr  out  1  sticky parity error; see Optional Feature. Cleared on i_start.

Behaviour:
- Reset values: o_rd, o_valid, o_busy, o_done, o_invalid and o_perr are 0. o_addr and o_data are 0. FIFO is empty. State is IDLE.
- States:
  - IDLE. On i_start with i_count≠0: load addr=i_first and remaining=i_count, go to RUN. On i_start with i_count=0: pulse o_done next cycle and stay in IDLE.
  - RUN. Assert o_rd when remaining≠0 and (FIFO occupancy + reads in flight) < 2. Each o_rd increments addr and decrements remaining. When remaining reaches 0, go to DRAIN.
  - DRAIN. Wait for the FIFO to empty and for no read to be in flight. The final channel handshake (o_valid & i_ready) pulses o_done, then the state returns to IDLE.
- Address wrap: the address after BUF_LEN-1 is 0. The block never drives o_addr ≥ BUF_LEN, provided i_first < BUF_LEN.
- Conversion is combinational on i_rdata and the result is written into the FIFO in the cycle the read data returns. BCD groups are {b,a}, low nibble 1..9 / 1010 / 1011 / 1100:
  - 00: F1..F9 / F0 / 7B / 7C
  - 01: 61 for nibble 1; E2..E9 for nibbles 2..9 / 50 / 6B / 6C
  - 10: D1..D9 / 60 / 5B / 5C
  - 11: C1..C9 / 4E / 4B / 4C
- Dual-encoded codes always return the first graphic: 001011→7B, 001100→7C, 011100→6C, 111100→4C.
- s=1: output 40 regardless of bits 5:0. o_invalid is not set.
- Low nibble 0000 or 1101..1111 with s=0: output 40 and set o_invalid.
- FIFO rules:
  - Head is driven on o_data with o_valid=1. A byte is accepted when o_valid & i_ready in the same cycle.
  - A push and a pop in the same cycle leave the occupancy unchanged.
  - The read-issue rule guarantees the FIFO is never written while full. The bench asserts this.
- i_ready low for any number of cycles stalls the block. No byte is lost or duplicated. o_data is stable while o_valid=1 and i_ready=0.
- i_abort has priority over every other input, including a simultaneous i_start:
  - Next cycle: FIFO flushed, in-flight read data discarded, o_valid=0, IDLE.
  - o_done is not pulsed. The sticky flags are held.
- Asynchronous reset mid-transfer: all state is cleared immediately. No o_done pulse.

Optional Feature:
- Macro: BCD_PARITY_EN.
- Defined:
  - Odd parity over i_rdata[7:0] is checked on every returned read.
  - Even parity sets o_perr. The byte is still converted and delivered.
- Undefined:
  - i_rdata[7] is ignored and o_perr is tied to 0.

Test Plan:
- Basic transfer: i_first=0, i_count=4; buffer holds 110001, 001010, 011011, 101011 (s=0), i_ready=1. Required: o_data = C1, F0, 6B, 5B; o_done one cycle after the 4th accept; o_invalid=0.
- Blank and invalid codes: buffer holds {s=1, 000000}, {s=0, 001101}, {s=0, 111100}. Required: 40, 40, 4C; o_invalid=1 after the 2nd byte.
- Address wrap and backpressure: i_first=130, i_count=4, i_ready toggled 1/0 every cycle. Required: o_addr sequence 130, 131, 0, 1; exactly 4 bytes in order; o_data stable during stalls; FIFO never overflows.
- Abort: i_abort pulsed after the 2nd accept of an i_count=10 transfer. Required: o_valid=0 next cycle; o_busy=0; no o_done; a new i_start is accepted two cycles later.
- Zero count and async reset: i_start with i_count=0 → o_done pulse with no o_rd. Asynchronous reset asserted mid-transfer → all outputs 0 immediately.
- BCD_PARITY_EN: one word with even parity. Required: o_perr=1, data byte still delivered. With the macro undefined, o_perr stays 0.
